// File: rtl/npc_seq_pkg.sv
// npc_seq_pkg
//   Shared types and constants for the NPC stage sequencer.
//   - state_e      : sequencer FSM states
//   - CAUSE_*      : halt_cause encodings reported on the halt_cause port
//   - is_wait_state: true for states in which the bus watchdog runs
package npc_seq_pkg;

  typedef enum logic [2:0] {
    IF_REQ   = 3'd0,
    IF_WAIT  = 3'd1,
    ID       = 3'd2,
    MEM_REQ  = 3'd3,
    MEM_WAIT = 3'd4,
    WB       = 3'd5,
    HALT     = 3'd6
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  function automatic logic is_wait_state(input state_e s);
    return (s == IF_WAIT) || (s == MEM_WAIT);
  endfunction

endpackage

// File: rtl/npc_seq_watchdog.sv
// npc_seq_watchdog
//   Cycle counter that flags a bus response that never arrives.
//   expired is high during the TIMEOUT_CYC-th consecutive enabled cycle
//   since the last clear, so the owner can leave the wait state on the
//   following edge. TIMEOUT_CYC = 0 removes the counter entirely.
// Ports:
//   clk     in  clock
//   rst     in  synchronous reset, active-high
//   clr     in  restart the count (takes priority over en)
//   en      in  count this cycle
//   expired out timeout reached in this cycle
module npc_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_wd;
      assign unused_wd = ^{clk, rst, clr, en};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      // Saturates at LAST so a stalled enable never wraps back to zero.
      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired = en && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/npc_stage_sequencer.sv
// npc_stage_sequencer
//   Multi-cycle control FSM for the NPC core. Steps the enable-gated PC,
//   IR and regfile write port through fetch, decode, memory and writeback,
//   handshakes with the fetch and load/store ports, and halts on ebreak,
//   illegal instruction or bus timeout.
//   Optional build macro NPC_SEQ_PERF_CNT_EN adds perf_cycles/perf_instret.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IF_REQ   | fetch request at current PC, wait for ifu_req_ready
//   IF_WAIT  | wait for instruction data; ir_en on arrival
//   ID       | sample decode class, choose next stage
//   MEM_REQ  | load/store request, held until lsu_req_ready
//   MEM_WAIT | wait for load data / store completion
//   WB       | rf_wen (if latched) and pc_en for one cycle
//   HALT     | stopped until rst; halt_cause holds the reason
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ifu_req_valid/ready            fetch request handshake
//   ifu_resp_valid                 instruction data valid
//   lsu_req_valid/we/ready         load/store request handshake
//   lsu_resp_valid                 load data valid / store complete
//   dec_is_load/store/ebreak       decoded class, valid in ID
//   dec_illegal, dec_rd_wen        decoded class / rd write, valid in ID
//   ir_en, pc_en, rf_wen           state register enables
//   halted, halt_cause             stop indication and reason
//   perf_cycles, perf_instret      (NPC_SEQ_PERF_CNT_EN) perf counters
module npc_stage_sequencer
  import npc_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned PERF_W      = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ifu_req_valid,
  input  logic              ifu_req_ready,
  input  logic              ifu_resp_valid,
  output logic              lsu_req_valid,
  output logic              lsu_req_we,
  input  logic              lsu_req_ready,
  input  logic              lsu_resp_valid,
  input  logic              dec_is_load,
  input  logic              dec_is_store,
  input  logic              dec_is_ebreak,
  input  logic              dec_illegal,
  input  logic              dec_rd_wen,
  output logic              ir_en,
  output logic              pc_en,
  output logic              rf_wen,
  output logic              halted,
  output logic [1:0]        halt_cause
`ifdef NPC_SEQ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_instret
`endif
);

  state_e     state_q, state_d;
  logic       we_q, we_d;
  logic       wen_q, wen_d;
  logic [1:0] cause_q, cause_d;
  logic       wd_expired;

  npc_seq_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_d != state_q),
    .en     (is_wait_state(state_q)),
    .expired(wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    wen_d         = wen_q;
    cause_d       = cause_q;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_we    = 1'b0;
    ir_en         = 1'b0;
    pc_en         = 1'b0;
    rf_wen        = 1'b0;
    halted        = 1'b0;

    case (state_q)
      IF_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) state_d = IF_WAIT;
      end

      // A response in the same cycle as the timeout still wins.
      IF_WAIT: begin
        if (ifu_resp_valid) begin
          ir_en   = 1'b1;
          state_d = ID;
        end else if (wd_expired) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = HALT;
        end
      end

      ID: begin
        if (dec_illegal) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = HALT;
        end else if (dec_is_ebreak) begin
          cause_d = CAUSE_EBREAK;
          state_d = HALT;
        end else if (dec_is_load || dec_is_store) begin
          // Store takes precedence for the write-back flag so a store never
          // writes rd, even on a malformed load+store decode.
          we_d    = dec_is_store;
          wen_d   = dec_rd_wen && dec_is_load && !dec_is_store;
          state_d = MEM_REQ;
        end else begin
          we_d    = 1'b0;
          wen_d   = dec_rd_wen;
          state_d = WB;
        end
      end

      MEM_REQ: begin
        lsu_req_valid = 1'b1;
        lsu_req_we    = we_q;
        if (lsu_req_ready) state_d = MEM_WAIT;
      end

      MEM_WAIT: begin
        if (lsu_resp_valid) begin
          state_d = WB;
        end else if (wd_expired) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = HALT;
        end
      end

      WB: begin
        rf_wen  = wen_q;
        pc_en   = 1'b1;
        state_d = IF_REQ;
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = IF_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IF_REQ;
      we_q    <= 1'b0;
      wen_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      wen_q   <= wen_d;
      cause_q <= cause_d;
    end
  end

  assign halt_cause = cause_q;

`ifdef NPC_SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] perf_cycles_q, perf_cycles_d;
  logic [PERF_W-1:0] perf_instret_q, perf_instret_d;

  always_comb begin
    perf_cycles_d  = perf_cycles_q;
    perf_instret_d = perf_instret_q;
    if (state_q != HALT) perf_cycles_d = perf_cycles_q + PERF_W'(1);
    if (state_q == WB) perf_instret_d = perf_instret_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q  <= '0;
      perf_instret_q <= '0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_instret_q <= perf_instret_d;
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_instret = perf_instret_q;
`endif

endmodule
